piezo_tone_seq: RTL and testbench

PIEZO_TONE_SEQ -- requirements
Module: piezo_tone_seq

---
 rtl/piezo_tone_seq.sv | 173 +++++++++++++++++
 tb/tb_piezo_tone_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/piezo_tone_seq.sv
`default_nettype none
// ============================================================================
//  Module   : piezo_tone_seq
//  Purpose  : Single-note piezo tone sequencer. An accepted start request
//             latches a digit code, a duration and a continuous-mode flag.
//             The design then drives a square wave whose half-period comes
//             from TONE_TABLE. The note ends after 'dur' ticks, or on stop
//             when in continuous mode, or on stop at any time.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   rising-edge clock
//    rst    in   synchronous active-high reset
//    start  in   note request strobe (accepted only in IDLE)
//    stop   in   abort strobe
//    cont   in   continuous mode, sampled with start
//    digit  in   tone select, sampled with start
//    dur    in   note length in ticks, sampled with start
//    tick   in   one-cycle duration timebase strobe
//    busy   out  note in progress (PLAY state)
//    done   out  one-cycle completion pulse
//    piezo  out  square-wave drive
//    note   out  last latched digit
// ============================================================================
module piezo_tone_seq #(
    parameter int NUM_TONES = 10,
    parameter int SEL_W     = 4,
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 16,
    parameter logic [NUM_TONES*DIV_W-1:0] TONE_TABLE = {
        16'd758, 16'd851, 16'd956, 16'd1012, 16'd1136,
        16'd1276, 16'd1432, 16'd1517, 16'd1703, 16'd1911
    }
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cont,
    input  logic [SEL_W-1:0] digit,
    input  logic [DUR_W-1:0] dur,
    input  logic             tick,
    output logic             busy,
    output logic             done,
    output logic             piezo,
    output logic [SEL_W-1:0] note
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Lookup covers every representable code; codes beyond NUM_TONES read 0,
    // which makes them silent without a separate range check.
    localparam int c_tbl_n = 2 ** SEL_W;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [SEL_W-1:0] r_note;
    logic [DUR_W-1:0] r_dur;
    logic             r_cont;
    logic [DIV_W-1:0] r_hp_cnt;
    logic [DUR_W-1:0] r_tick_cnt;
    logic             r_piezo;

    logic [DIV_W-1:0] w_tbl [c_tbl_n];
    logic [DIV_W-1:0] w_entry;
    logic [DIV_W-1:0] w_half_last;
    logic             w_silent;
    logic [DUR_W-1:0] w_tick_next;
    logic             w_final;
    logic             w_accept;

    generate
        for (genvar gi = 0; gi < c_tbl_n; gi++) begin : g_tbl
            if (gi < NUM_TONES) begin : g_used
                assign w_tbl[gi] = TONE_TABLE[gi*DIV_W +: DIV_W];
            end else begin : g_unused
                assign w_tbl[gi] = '0;
            end
        end
    endgenerate

    assign w_entry     = w_tbl[r_note];
    assign w_silent    = (w_entry == '0);
    assign w_half_last = w_entry - DIV_W'(1);
    assign w_tick_next = r_tick_cnt + DUR_W'(1);
    assign w_accept    = (r_state == S_IDLE) && start && !stop;

    // Note completes either immediately (dur of zero) or on the tick that
    // brings the count up to dur. Continuous mode never completes on its own.
    assign w_final = !r_cont && ((r_dur == '0) || (tick && (w_tick_next == r_dur)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; stop has priority over completion
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_next = S_IDLE;
                end else if (w_final) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Request latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_note <= '0;
            r_dur  <= '0;
            r_cont <= 1'b0;
        end else if (w_accept) begin
            r_note <= digit;
            r_dur  <= dur;
            r_cont <= cont;
        end
    end

    // Counters and square wave. They only advance while remaining in PLAY;
    // any other transition clears them, so piezo is 0 outside PLAY and
    // every note starts from a clean phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hp_cnt   <= '0;
            r_tick_cnt <= '0;
            r_piezo    <= 1'b0;
        end else if ((r_state == S_PLAY) && (w_next == S_PLAY)) begin
            if (!w_silent) begin
                if (r_hp_cnt == w_half_last) begin
                    r_hp_cnt <= '0;
                    r_piezo  <= ~r_piezo;
                end else begin
                    r_hp_cnt <= r_hp_cnt + DIV_W'(1);
                end
            end
            if (tick && !r_cont) begin
                r_tick_cnt <= w_tick_next;
            end
        end else begin
            r_hp_cnt   <= '0;
            r_tick_cnt <= '0;
            r_piezo    <= 1'b0;
        end
    end

    // Output logic
    always_comb begin
        busy  = (r_state == S_PLAY);
        done  = (r_state == S_DONE);
        piezo = r_piezo;
        note  = r_note;
    end

endmodule
`default_nettype wire

// File: tb/tb_piezo_tone_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piezo_tone_seq
//  Purpose  : Self-checking bench for piezo_tone_seq. A behavioural model
//             tracks the note phase, edges elapsed since the note began and
//             the ticks seen. It predicts the square wave arithmetically as
//             (edges / half_period) mod 2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piezo_tone_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        cont;
    logic [3:0]  digit;
    logic [15:0] dur;
    logic        tick;
    logic        busy;
    logic        done;
    logic        piezo;
    logic [3:0]  note;

    piezo_tone_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .digit (digit),
        .dur   (dur),
        .tick  (tick),
        .busy  (busy),
        .done  (done),
        .piezo (piezo),
        .note  (note)
    );

    always #5 clk = ~clk;

    int n_cmp       = 0;
    int n_fail      = 0;
    int n_done_seen = 0;

    int tone_tbl [10] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956, 851, 758};

    // Model: 0 = idle, 1 = playing, 2 = finished
    int m_phase = 0;
    int m_k     = 0;
    int m_ticks = 0;
    int m_dur   = 0;
    int m_cont  = 0;
    int m_note  = 0;

    function automatic int entry_of(input int n);
        return (n < 10) ? tone_tbl[n] : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_phase = 0; m_note = 0; m_k = 0; m_ticks = 0;
        end else begin
            case (m_phase)
                0: if (start && !stop) begin
                    m_phase = 1; m_note = int'(digit); m_dur = int'(dur);
                    m_cont = int'(cont); m_k = 0; m_ticks = 0;
                end
                1: begin
                    if (stop) m_phase = 0;
                    else if (m_cont == 0 && (m_dur == 0 || (tick && m_ticks + 1 == m_dur)))
                        m_phase = 2;
                    else begin
                        m_k++;
                        if (tick && m_cont == 0) m_ticks++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic check_outputs();
        int e;
        int exp_pz;
        e = entry_of(m_note);
        exp_pz = (m_phase == 1 && e != 0) ? ((m_k / (e == 0 ? 1 : e)) % 2) : 0;
        chk("busy",  32'(busy),  32'(m_phase == 1));
        chk("done",  32'(done),  32'(m_phase == 2));
        chk("piezo", 32'(piezo), 32'(exp_pz));
        chk("note",  32'(note),  32'(m_note));
        if (done === 1'b1) n_done_seen++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic play_note(input int d, input int du, input int c, input int gap,
                             input int maxc, input int stop_at, input int restart_at,
                             input int exp_done);
        int cnt;
        int done0;
        done0 = n_done_seen;
        digit = 4'(d); dur = 16'(du); cont = c[0]; start = 1'b1; stop = 1'b0; tick = 1'b0;
        step();
        start = 1'b0;
        digit = 4'($urandom); dur = 16'($urandom); cont = 1'($urandom);
        cnt = 0;
        while (m_phase != 0 && cnt < maxc) begin
            tick  = ((cnt % gap) == gap - 1);
            stop  = (cnt == stop_at);
            start = (cnt == restart_at);
            step();
            cnt++;
        end
        tick = 1'b0; stop = 1'b0; start = 1'b0;
        chk("note_finished_busy", 32'(busy), 32'd0);
        if (exp_done >= 0) chk("done_count", 32'(n_done_seen - done0), 32'(exp_done));
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; digit = '0; dur = '0; tick = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("reset_piezo", 32'(piezo), 32'd0);
        chk("reset_note",  32'(note),  32'd0);
        rst = 1'b0;
        step();

        // digit 5, three ticks 5000 cycles apart
        play_note(5, 3, 0, 5000, 16000, -1, -1, 1);

        // out-of-range digit is silent but keeps timing
        play_note(12, 2, 0, 300, 700, -1, -1, 1);
        chk("silent_note_held", 32'(note), 32'd12);

        // zero duration
        play_note(0, 0, 0, 10, 20, -1, -1, 1);

        // continuous mode, 100 ticks then stop
        play_note(9, 1, 1, 20, 2100, 2000, -1, 0);

        // start+stop together in IDLE: request dropped
        digit = 4'd7; dur = 16'd2; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        chk("startstop_busy", 32'(busy), 32'd0);
        chk("startstop_note", 32'(note), 32'd9);

        // retrigger ignored, stop coincident with the final tick
        play_note(3, 3, 0, 100, 400, 299, 150, 0);
        chk("retrig_note", 32'(note), 32'd3);

        // reset mid-note, with start/stop/tick also asserted
        digit = 4'd4; dur = 16'd2; cont = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick = (i == 300);
            step();
        end
        rst = 1'b1; start = 1'b1; stop = 1'b1; tick = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_done",  32'(done),  32'd0);
        chk("midrst_piezo", 32'(piezo), 32'd0);
        chk("midrst_note",  32'(note),  32'd0);
        step();
        play_note(4, 1, 0, 900, 905, -1, -1, 1);

        // randomized notes, some aborted
        for (int r = 0; r < 6; r++) begin
            int rd, rdu, rgap, rmax, rstop;
            rd   = int'($urandom_range(0, 15));
            rdu  = int'($urandom_range(0, 4));
            rgap = int'($urandom_range(1, 400));
            rmax = rdu * rgap + 5;
            rstop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, rmax)) : -1;
            play_note(rd, rdu, 0, rgap, rmax, rstop, int'($urandom_range(0, rmax)),
                      (rstop < 0) ? 1 : -1);
        end
        play_note(int'($urandom_range(0, 9)), 0, 1, 7, 1600, 1500, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
